rect_fill_drawer: RTL and testbench

- Parametrised successor to the fixed 4x4 square plotter.
- Fills a W x H rectangle (1..2^W_BITS-1 per side) at a latched base coordinate, one pixel per clock, in raster order.
- Drives the VGA adapter's x/y/colour/plot inputs. Offers a go/busy/done handshake to the game-logic FSMs.
- Supports draw (input colour) and erase (black) modes.

---
 rtl/draw_pkg.sv | 13 +
 rtl/raster_counter.sv | 41 ++++
 rtl/rect_fill_drawer.sv | 117 +++++++++++
 tb/tb_rect_fill_drawer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and defaults for the rectangle fill drawer.
package draw_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam int unsigned DEF_X_BITS      = 8;
  localparam int unsigned DEF_Y_BITS      = 7;
  localparam int unsigned DEF_COLOUR_BITS = 3;
  localparam int unsigned DEF_SCREEN_W    = 160;
  localparam int unsigned DEF_SCREEN_H    = 120;
  localparam int unsigned COLOUR_BLACK    = 0;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y offset counter; last flags the final pixel of a w x h scan.
module raster_counter #(
  parameter int unsigned W_BITS = 4,
  parameter int unsigned H_BITS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              en,
  input  logic [W_BITS-1:0] w,
  input  logic [H_BITS-1:0] h,
  output logic [W_BITS-1:0] xoff,
  output logic [H_BITS-1:0] yoff,
  output logic              last
);

  logic x_end;
  logic y_end;

  assign x_end = (xoff == w - W_BITS'(1));
  assign y_end = (yoff == h - H_BITS'(1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xoff <= '0;
      yoff <= '0;
    end else if (clear) begin
      xoff <= '0;
      yoff <= '0;
    end else if (en) begin
      if (x_end) begin
        xoff <= '0;
        yoff <= yoff + H_BITS'(1);
      end else begin
        xoff <= xoff + W_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_drawer.sv
// Fills a W x H rectangle one pixel per clock for the VGA adapter.
// Optional screen-edge clipping is enabled by defining RECT_FILL_CLIP_EN.
module rect_fill_drawer
  import draw_pkg::*;
#(
  parameter int unsigned X_BITS      = DEF_X_BITS,
  parameter int unsigned Y_BITS      = DEF_Y_BITS,
  parameter int unsigned COLOUR_BITS = DEF_COLOUR_BITS,
  parameter int unsigned W_BITS      = 4,
  parameter int unsigned H_BITS      = 4,
  parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   go,
  input  logic                   draw,
  input  logic [X_BITS-1:0]      x_in,
  input  logic [Y_BITS-1:0]      y_in,
  input  logic [W_BITS-1:0]      rect_w,
  input  logic [H_BITS-1:0]      rect_h,
  input  logic [COLOUR_BITS-1:0] colour_in,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

`ifdef RECT_FILL_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  localparam logic [X_BITS:0] ScreenWLim = SCREEN_W[X_BITS:0];
  localparam logic [Y_BITS:0] ScreenHLim = SCREEN_H[Y_BITS:0];

  state_e                 state_q;
  logic [X_BITS-1:0]      base_x_q;
  logic [Y_BITS-1:0]      base_y_q;
  logic [W_BITS-1:0]      w_q;
  logic [H_BITS-1:0]      h_q;
  logic [COLOUR_BITS-1:0] colour_q;

  logic [W_BITS-1:0] xoff;
  logic [H_BITS-1:0] yoff;
  logic              last;
  logic              accept;
  logic              cnt_en;

  assign accept = (state_q == StIdle) && go;
  // Hold offsets on the final pixel so x/y keep their last-driven value afterwards.
  assign cnt_en = (state_q == StFill) && !last;

  raster_counter #(
    .W_BITS (W_BITS),
    .H_BITS (H_BITS)
  ) u_raster_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .en     (cnt_en),
    .w      (w_q),
    .h      (h_q),
    .xoff   (xoff),
    .yoff   (yoff),
    .last   (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      base_x_q <= '0;
      base_y_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go) begin
            base_x_q <= x_in;
            base_y_q <= y_in;
            w_q      <= rect_w;
            h_q      <= rect_h;
            colour_q <= draw ? colour_in : COLOUR_BITS'(COLOUR_BLACK);
            state_q  <= (rect_w == '0 || rect_h == '0) ? StDone : StFill;
          end
        end
        StFill: begin
          if (last) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // One extra bit keeps the unwrapped sum for the on-screen test.
  logic [X_BITS:0] x_full;
  logic [Y_BITS:0] y_full;
  logic            on_screen;

  assign x_full    = {1'b0, base_x_q} + {{(X_BITS + 1 - W_BITS){1'b0}}, xoff};
  assign y_full    = {1'b0, base_y_q} + {{(Y_BITS + 1 - H_BITS){1'b0}}, yoff};
  assign on_screen = (x_full < ScreenWLim) && (y_full < ScreenHLim);

  assign x      = x_full[X_BITS-1:0];
  assign y      = y_full[Y_BITS-1:0];
  assign colour = colour_q;
  assign plot   = (state_q == StFill) && (!ClipEn || on_screen);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_rect_fill_drawer.sv
// Scoreboard bench for rect_fill_drawer: stimulus pushes expected pixels, monitor checks them.
module tb_rect_fill_drawer;

`ifdef RECT_FILL_CLIP_EN
  localparam bit ClipOn = 1'b1;
`else
  localparam bit ClipOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       go = 1'b0;
  logic       draw = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [3:0] rect_w = '0;
  logic [3:0] rect_h = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  rect_fill_drawer dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .draw      (draw),
    .x_in      (x_in),
    .y_in      (y_in),
    .rect_w    (rect_w),
    .rect_h    (rect_h),
    .colour_in (colour_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_run = 0;
  int   last_busy = 0;

  // Expected pixels of a rectangle, stopping after max_pix pixels; optional done marker.
  function automatic void push_rect(int bx, int by, int w, int h, int c, int max_pix,
                                    bit with_done);
    exp_t e;
    int   n;
    n = 0;
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        if (n < max_pix) begin
          if (!ClipOn || ((bx + i) < 160 && (by + j) < 120)) begin
            e.is_done = 1'b0;
            e.x = 8'((bx + i) % 256);
            e.y = 7'((by + j) % 128);
            e.c = 3'(c);
            sb.push_back(e);
          end
        end
        n++;
      end
    end
    if (with_done) begin
      e = '0;
      e.is_done = 1'b1;
      sb.push_back(e);
    end
  endfunction

  // Monitor: pops one expectation for every plot or done cycle.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (busy) busy_run = busy_run + 1;
      else busy_run = 0;
      if (done) last_busy = busy_run;
      if (plot || done) begin
        n_cmp = n_cmp + 1;
        if (sb.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_output: got plot=%0b done=%0b x=%0d y=%0d, need nothing",
                   plot, done, x, y);
        end else begin
          e = sb.pop_front();
          if (e.is_done !== done || plot === e.is_done ||
              (plot && (x !== e.x || y !== e.y || colour !== e.c))) begin
            n_bad = n_bad + 1;
            $display("FAIL pixel: got plot=%0b done=%0b (%0d,%0d) c=%0d, need done=%0b (%0d,%0d) c=%0d",
                     plot, done, x, y, colour, e.is_done, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic start(int bx, int by, int w, int h, int c, bit d);
    @(posedge clk);
    #1;
    x_in = 8'(bx); y_in = 7'(by); rect_w = 4'(w); rect_h = 4'(h);
    colour_in = 3'(c); draw = d; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_done(int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(done === 1'b1), 1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 resetn = 1'b0;
    #1;
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_colour", colour, 0);
    chk("reset_plot", plot, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;

    // Basic 4x4 fill
    push_rect(10, 20, 4, 4, 5, 1000, 1'b1);
    start(10, 20, 4, 4, 5, 1'b1);
    wait_done(40);
    chk("busy_len_basic", last_busy, 17);
    @(negedge clk);
    #1 chk("idle_after_basic", busy, 0);

    // Erase, non-square 3x2
    push_rect(0, 0, 3, 2, 0, 1000, 1'b1);
    start(0, 0, 3, 2, 7, 1'b0);
    wait_done(40);
    chk("busy_len_erase", last_busy, 7);

    // Degenerate width
    push_rect(3, 3, 0, 5, 2, 1000, 1'b1);
    start(3, 3, 0, 5, 2, 1'b1);
    @(negedge clk);
    #1;
    chk("degen_busy", busy, 1);
    chk("degen_done", done, 1);
    chk("degen_plot", plot, 0);
    @(negedge clk);
    #1 chk("degen_idle", busy, 0);

    // Inputs changed mid-fill are ignored; held go restarts after one idle cycle
    push_rect(30, 40, 4, 4, 2, 1000, 1'b1);
    push_rect(50, 40, 4, 4, 2, 1000, 1'b1);
    start(30, 40, 4, 4, 2, 1'b1);
    repeat (5) @(posedge clk);
    #1 begin go = 1'b1; x_in = 8'd50; end
    wait_done(40);
    chk("busy_len_first", last_busy, 17);
    @(negedge clk);
    #1 chk("idle_gap_busy", busy, 0);
    @(posedge clk);
    #1 go = 1'b0;
    wait_done(40);
    chk("busy_len_second", last_busy, 17);

    // Asynchronous reset after pixel 7 has been presented
    push_rect(5, 5, 4, 4, 6, 8, 1'b0);
    start(5, 5, 4, 4, 6, 1'b1);
    repeat (7) @(posedge clk);
    #7 resetn = 1'b0;
    #1;
    chk("areset_plot", plot, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_x", x, 0);
    chk("areset_y", y, 0);
    chk("areset_colour", colour, 0);
    repeat (2) @(negedge clk);
    #3 resetn = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_plot", plot, 0);

    // Screen edge
    push_rect(158, 118, 4, 4, 1, 1000, 1'b1);
    start(158, 118, 4, 4, 1, 1'b1);
    wait_done(40);
    chk("busy_len_edge", last_busy, 17);

    // Maximum size, wrapping in both axes
    push_rect(250, 120, 15, 15, 4, 1000, 1'b1);
    start(250, 120, 15, 15, 4, 1'b1);
    wait_done(300);
    chk("busy_len_max", last_busy, 226);

    @(negedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
